regfile_rename: RTL and testbench
=================================

// Module: regfile_rename
// PURPOSE
//   Parametrised register file with per-register rename status (busy bit + producer tag) for the
//   Tomasulo dynamic pipeline. Issue stage marks destination registers busy with a reservation-station
//   tag; the common data bus (CDB) writes results back by tag match. Read ports return either a value
//   or a pending tag, with same-cycle CDB bypass. Sits between decode/issue and the reservation stations.
// PARAMETERS
//   DATA_W  32  register data width
//   ADDR_W   5  register address width; NREGS = 2**ADDR_W, register 0 hard-wired to zero
//   TAG_W    4  producer tag width (reservation-station id); every tag value incl. 0 is legal
// PORTS
//   clk        in   1       clock, all state updates on posedge
//   rst        in   1       asynchronous reset, active-high
//   iss_valid  in   1       issue: mark iss_rd busy with iss_tag
//   iss_rd     in   ADDR_W  issue destination register
//   iss_tag    in   TAG_W   issue producer tag
//   cdb_valid  in   1       CDB broadcast valid
//   cdb_tag    in   TAG_W   CDB producer tag
//   cdb_data   in   DATA_W  CDB result
//   flush      in   1       clear all busy bits (mispredict/exception recovery)
//   rena1/2    in   1       read port enable
//   raddr1/2   in   ADDR_W  read port address
//   rdata1/2   out  DATA_W  read value (valid when rbusy=0)
//   rbusy1/2   out  1       operand pending
//   rtag1/2    out  TAG_W   pending producer tag (valid when rbusy=1)
//   dbg_addr   in   ADDR_W  debug read address
//   dbg_data   out  DATA_W  debug read: raw register contents, no bypass
//   nbusy      out  ADDR_W+1 registered count of busy registers
// BEHAVIOUR
//   Reset (async, rst=1): all registers, busy bits, tags and nbusy cleared to 0; while rst=1 every
//     read output (rdata/rbusy/rtag/dbg_data) is 0.
//   CDB write (posedge): every reg i with busy[i] && tag[i]==cdb_tag && cdb_valid gets
//     Regs[i]<=cdb_data, busy[i]<=0. Multiple regs may match one broadcast; all update.
//   Issue (posedge, iss_valid && iss_rd!=0): busy[iss_rd]<=1, tag[iss_rd]<=iss_tag. iss_rd==0 ignored.
//   Issue + CDB on same reg same cycle: CDB value is written, but issue wins on status (busy=1, new tag).
//   Flush (posedge): all busy bits <=0; register values untouched; a same-cycle issue is dropped;
//     a same-cycle CDB write still lands in Regs.
//   Register 0: never busy, never written, always reads 0.
//   Read ports (combinational, priority order):
//     rena=0 or raddr=0 -> data 0, busy 0, tag 0;
//     busy[a] && cdb_valid && cdb_tag==tag[a] -> data=cdb_data, busy 0 (bypass);
//     busy[a] -> data=Regs[a], busy 1, tag=tag[a];
//     else data=Regs[a], busy 0, tag 0.
//   Reads see status BEFORE same-cycle issue; a new rename is visible from the next cycle.
//   nbusy: registered, equals popcount(busy) after each posedge update; 0 after reset/flush.
// TESTING
//   1 Reset: pulse rst mid-run with r5 busy -> all rdata/rbusy/nbusy 0 immediately, r5 reads 0 after.
//   2 Issue r5 tag 3; next cycle read r5 -> rbusy=1, rtag=3, nbusy=1; CDB tag 3 data 0xDEADBEEF
//     same cycle -> rdata=0xDEADBEEF, rbusy=0; next cycle Regs[5]=0xDEADBEEF, nbusy=0.
//   3 Rename chain: issue r5 tag 3, then r5 tag 7; CDB tag 3 -> r5 stays busy tag 7, value unchanged;
//     CDB tag 7 data 0x12 -> r5=0x12.
//   4 Same-cycle issue r6 tag 2 + CDB tag 1 (r6 old tag 1) data 0x55 -> Regs[6]=0x55, busy tag 2.
//   5 Issue r1,r2,r3 (nbusy=3), then flush with issue r4 -> nbusy=0, r4 not busy, values kept.
//   6 Issue r0 tag 4, CDB tag 4 data 0xFF -> r0 reads 0, rbusy=0, nbusy=0; rena=0 -> all outputs 0.

Source files
------------

// File: rtl/regfile_rename.sv
// Register file with per-register rename status (busy + producer tag) for a Tomasulo pipeline.
// Issue renames destinations; CDB broadcasts retire them by tag; read ports bypass the live CDB.

module regfile_rename_rdport #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic              en,
  input  logic              busy,
  input  logic [TAG_W-1:0]  tag,
  input  logic [DATA_W-1:0] val,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic [DATA_W-1:0] rdata,
  output logic              rbusy,
  output logic [TAG_W-1:0]  rtag
);
  always_comb begin
    rdata = '0;
    rbusy = 1'b0;
    rtag  = '0;
    if (en) begin
      if (busy && cdb_valid && cdb_tag == tag) begin
        rdata = cdb_data;
      end else if (busy) begin
        rdata = val;
        rbusy = 1'b1;
        rtag  = tag;
      end else begin
        rdata = val;
      end
    end
  end
endmodule

module regfile_rename #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic [TAG_W-1:0]  iss_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              flush,
  input  logic              rena1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  output logic              rbusy1,
  output logic [TAG_W-1:0]  rtag1,
  input  logic              rena2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic              rbusy2,
  output logic [TAG_W-1:0]  rtag2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [ADDR_W:0]   nbusy
);
  localparam int NREGS = 1 << ADDR_W;

  logic [NREGS-1:0][DATA_W-1:0] regs;
  logic [NREGS-1:0][TAG_W-1:0]  tags;
  logic [NREGS-1:0]             busy, hit, busy_nxt;
  logic [ADDR_W:0]              cnt;
  logic                         iss_ok;

  assign iss_ok = iss_valid && iss_rd != '0 && !flush;

  // Issue overrides a same-cycle CDB retire on status; flush overrides both.
  always_comb begin
    for (int i = 0; i < NREGS; i++)
      hit[i] = cdb_valid && busy[i] && tags[i] == cdb_tag;
    busy_nxt = busy & ~hit;
    if (flush) busy_nxt = '0;
    else if (iss_ok) busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
    cnt = '0;
    for (int i = 0; i < NREGS; i++)
      cnt = cnt + {{ADDR_W{1'b0}}, busy_nxt[i]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs  <= '0;
      tags  <= '0;
      busy  <= '0;
      nbusy <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++)
        if (hit[i]) regs[i] <= cdb_data;
      if (iss_ok) tags[iss_rd] <= iss_tag;
      busy  <= busy_nxt;
      nbusy <= cnt;
    end
  end

  logic [1:0]                   ren;
  logic [1:0][ADDR_W-1:0]       ra;
  logic [1:0][DATA_W-1:0]       rd;
  logic [1:0]                   rb;
  logic [1:0][TAG_W-1:0]        rt;

  assign ren = {rena2, rena1};
  assign ra  = {raddr2, raddr1};

  for (genvar p = 0; p < 2; p++) begin : g_rd
    regfile_rename_rdport #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_rd (
      .en        (!rst && ren[p] && ra[p] != '0),
      .busy      (busy[ra[p]]),
      .tag       (tags[ra[p]]),
      .val       (regs[ra[p]]),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .rdata     (rd[p]),
      .rbusy     (rb[p]),
      .rtag      (rt[p])
    );
  end

  assign rdata1   = rd[0];
  assign rbusy1   = rb[0];
  assign rtag1    = rt[0];
  assign rdata2   = rd[1];
  assign rbusy2   = rb[1];
  assign rtag2    = rt[1];
  assign dbg_data = rst ? '0 : regs[dbg_addr];
endmodule

// File: tb/tb_regfile_rename.sv
// Directed bench for regfile_rename: array-based reference model checked every negedge,
// plus literal expectations for the named scenarios.

module tb_regfile_rename;
  localparam int DW = 32, AW = 5, TW = 4, NR = 32;

  logic          clk = 1'b0, rst = 1'b1;
  logic          iss_valid = 0, cdb_valid = 0, flush = 0, rena1 = 0, rena2 = 0;
  logic [AW-1:0] iss_rd = 0, raddr1 = 0, raddr2 = 0, dbg_addr = 0;
  logic [TW-1:0] iss_tag = 0, cdb_tag = 0;
  logic [DW-1:0] cdb_data = 0;
  logic [DW-1:0] rdata1, rdata2, dbg_data;
  logic          rbusy1, rbusy2;
  logic [TW-1:0] rtag1, rtag2;
  logic [AW:0]   nbusy;

  int checks = 0, errors = 0;

  regfile_rename #(.DATA_W(DW), .ADDR_W(AW), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_tag(iss_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .flush(flush),
    .rena1(rena1), .raddr1(raddr1), .rdata1(rdata1), .rbusy1(rbusy1), .rtag1(rtag1),
    .rena2(rena2), .raddr2(raddr2), .rdata2(rdata2), .rbusy2(rbusy2), .rtag2(rtag2),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .nbusy(nbusy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: plain arrays of value, pending flag and producer tag.
  logic [DW-1:0] m_val [NR];
  logic          m_pend[NR];
  logic [TW-1:0] m_tag [NR];
  int            m_cnt;

  always @(posedge clk or posedge rst) begin
    logic [DW-1:0] nv [NR];
    logic          np [NR];
    logic [TW-1:0] nt [NR];
    int c;
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        m_val[i] <= '0; m_pend[i] <= 1'b0; m_tag[i] <= '0;
      end
      m_cnt <= 0;
    end else begin
      nv = m_val; np = m_pend; nt = m_tag;
      if (cdb_valid)
        for (int i = 1; i < NR; i++)
          if (m_pend[i] && m_tag[i] == cdb_tag) begin
            nv[i] = cdb_data; np[i] = 1'b0;
          end
      if (flush) for (int i = 0; i < NR; i++) np[i] = 1'b0;
      else if (iss_valid && iss_rd != 0) begin
        np[iss_rd] = 1'b1; nt[iss_rd] = iss_tag;
      end
      c = 0;
      for (int i = 0; i < NR; i++) if (np[i]) c++;
      m_val <= nv; m_pend <= np; m_tag <= nt; m_cnt <= c;
    end
  end

  function automatic logic [DW+TW:0] model_rd(input logic en, input logic [AW-1:0] a);
    if (rst || !en || a == 0) return '0;
    if (m_pend[a] && cdb_valid && cdb_tag == m_tag[a]) return {cdb_data, 1'b0, {TW{1'b0}}};
    if (m_pend[a]) return {m_val[a], 1'b1, m_tag[a]};
    return {m_val[a], 1'b0, {TW{1'b0}}};
  endfunction

  always @(negedge clk) begin
    chk("port1", {rdata1, rbusy1, rtag1}, model_rd(rena1, raddr1));
    chk("port2", {rdata2, rbusy2, rtag2}, model_rd(rena2, raddr2));
    chk("dbg", dbg_data, rst ? '0 : m_val[dbg_addr]);
    chk("nbusy", nbusy, m_cnt);
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [AW-1:0] r, input logic [TW-1:0] t);
    iss_valid = 1; iss_rd = r; iss_tag = t; cyc(); iss_valid = 0;
  endtask

  task automatic cdb(input logic [TW-1:0] t, input logic [DW-1:0] d);
    cdb_valid = 1; cdb_tag = t; cdb_data = d; cyc(); cdb_valid = 0;
  endtask

  initial begin
    repeat (2) cyc();
    #1 chk("reset nbusy", nbusy, 0);
    chk("reset dbg", dbg_data, 0);
    rst = 0;
    cyc();

    // Issue then bypass
    issue(5, 3);
    rena1 = 1; raddr1 = 5; #1;
    chk("t2 rbusy", rbusy1, 1); chk("t2 rtag", rtag1, 3); chk("t2 nbusy", nbusy, 1);
    cdb_valid = 1; cdb_tag = 3; cdb_data = 32'hDEADBEEF; #1;
    chk("t2 bypass data", rdata1, 32'hDEADBEEF); chk("t2 bypass busy", rbusy1, 0);
    cyc(); cdb_valid = 0; dbg_addr = 5; #1;
    chk("t2 reg5", dbg_data, 32'hDEADBEEF); chk("t2 nbusy0", nbusy, 0);

    // Rename chain: stale tag must not retire r5
    issue(5, 3); issue(5, 7);
    cdb(3, 32'h0000AAAA); #1;
    chk("t3 still busy", rbusy1, 1); chk("t3 tag7", rtag1, 7);
    chk("t3 value kept", dbg_data, 32'hDEADBEEF);
    cdb(7, 32'h12); #1;
    chk("t3 r5", dbg_data, 32'h12); chk("t3 free", rbusy1, 0);

    // Same-cycle issue + CDB on one register
    issue(6, 1);
    iss_valid = 1; iss_rd = 6; iss_tag = 2; cdb_valid = 1; cdb_tag = 1; cdb_data = 32'h55;
    cyc(); iss_valid = 0; cdb_valid = 0;
    rena2 = 1; raddr2 = 6; dbg_addr = 6; #1;
    chk("t4 r6", dbg_data, 32'h55); chk("t4 busy", rbusy2, 1); chk("t4 tag", rtag2, 2);
    cdb(2, 32'h66);

    // Flush with concurrent issue and CDB
    issue(1, 1); issue(2, 2); issue(3, 3); #1;
    chk("t5 nbusy3", nbusy, 3);
    flush = 1; iss_valid = 1; iss_rd = 4; iss_tag = 5; cdb_valid = 1; cdb_tag = 1; cdb_data = 32'h77;
    cyc(); flush = 0; iss_valid = 0; cdb_valid = 0;
    raddr1 = 4; dbg_addr = 1; #1;
    chk("t5 nbusy0", nbusy, 0); chk("t5 r4 free", rbusy1, 0); chk("t5 r1 cdb", dbg_data, 32'h77);
    dbg_addr = 5; #1 chk("t5 r5 kept", dbg_data, 32'h12);

    // Register 0 and read enable
    issue(0, 4);
    raddr1 = 0; cdb_valid = 1; cdb_tag = 4; cdb_data = 32'hFF; #1;
    chk("t6 r0 data", rdata1, 0); chk("t6 r0 busy", rbusy1, 0);
    cyc(); cdb_valid = 0; dbg_addr = 0; #1;
    chk("t6 nbusy", nbusy, 0); chk("t6 r0 raw", dbg_data, 0);
    issue(5, 9);
    rena1 = 0; raddr1 = 5; #1;
    chk("t6 rena0", {rdata1, rbusy1, rtag1}, 0);
    rena1 = 1; #1 chk("t6 rena1 tag", rtag1, 9);

    // Async reset mid-run with r5 busy
    rst = 1; #1;
    chk("t1 rbusy", rbusy1, 0); chk("t1 rdata", rdata1, 0); chk("t1 nbusy", nbusy, 0);
    cyc(); rst = 0; dbg_addr = 5; #1;
    chk("t1 r5 cleared", dbg_data, 0); chk("t1 r5 free", rbusy1, 0);

    // Random traffic checked by the model each cycle
    for (int n = 0; n < 300; n++) begin
      iss_valid = ($urandom_range(0, 2) != 0); iss_rd = AW'($urandom_range(0, 7));
      iss_tag = TW'($urandom); cdb_valid = $urandom_range(0, 1) == 1;
      cdb_tag = TW'($urandom); cdb_data = $urandom; flush = ($urandom_range(0, 19) == 0);
      rena1 = ($urandom_range(0, 3) != 0); rena2 = ($urandom_range(0, 3) != 0);
      raddr1 = AW'($urandom_range(0, 7)); raddr2 = AW'($urandom_range(0, 7));
      dbg_addr = AW'($urandom_range(0, 7));
      cyc();
    end
    iss_valid = 0; cdb_valid = 0; flush = 0;
    cyc(); cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
